vc_fifo: RTL and testbench
==========================

# vc_fifo

Multi-channel synchronous FIFO for the NoC router input ports: NVC independent virtual-channel queues share one storage array, one write port and one read port, each port addressed by a VC index. It is the parametrised successor to the single-queue FIFO. It adds the following, per VC: fill level, almost-full, sticky overflow/underflow error flags and flush. The router's VC allocator drives the read side; the link receiver drives the write side.

## Interface
- BW, 8, data width in bits
- LGFLEN, 4, log2 of per-VC depth (depth D = 2^LGFLEN, LGFLEN ≥ 1)
- NVC, 2, number of virtual channels (≥ 1)
- AFULL, D-2, almost-full threshold per VC (1..D)
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_wr  in  1  write request
- i_wr_vc  in  VCW  target VC of write (VCW = max(1, clog2(NVC)))
- i_data  in  BW  write data
- i_rd  in  1  read request (pop)
- i_rd_vc  in  VCW  VC to read/pop
- o_data  out  BW  head entry of VC i_rd_vc (combinational)
- o_valid  out  1  VC i_rd_vc non-empty (combinational)
- i_flush  in  NVC  per-VC flush bitmask
- o_full  out  NVC  per-VC full
- o_afull  out  NVC  per-VC fill ≥ AFULL
- o_empty  out  NVC  per-VC empty
- o_fill  out  NVC*(LGFLEN+1)  per-VC fill, VC v at bits [v*(LGFLEN+1) +: LGFLEN+1]
- o_ovf  out  NVC  sticky: write attempted to full VC
- o_udf  out  NVC  sticky: read attempted on empty VC

## Operation
- Storage: one array of NVC*D words; VC v occupies entries [v*D, v*D+D-1]; address = {vc, ptr[LGFLEN-1:0]}.
- Per VC: wr_ptr, rd_ptr, each LGFLEN+1 bits, wrapping modulo 2^(LGFLEN+1); fill = wr_ptr − rd_ptr (LGFLEN+1 bits, unsigned).
- Status flags:
  - full = (fill == D)
  - empty = (fill == 0)
  - afull = (fill ≥ AFULL)
- Accepted write: i_wr && !full[i_wr_vc] && !i_flush[i_wr_vc]. It stores i_data and increments wr_ptr.
- Accepted read: i_rd && !empty[i_rd_vc] && !i_flush[i_rd_vc]. It increments rd_ptr.
- Rejected write to a full VC (not flushed) sets o_ovf[vc]. Data is dropped and no pointer moves.
- Rejected read from an empty VC (not flushed) sets o_udf[vc]. No pointer moves.
- i_wr_vc/i_rd_vc ≥ NVC: request ignored, no flag set.
- Simultaneous write and read, same VC:
  - Both are evaluated against pre-edge flags.
  - Full VC: the read succeeds and the write is rejected (sets ovf); there is no pass-through.
  - Empty VC: the write succeeds and the read is rejected (sets udf); there is no bypass.
  - Otherwise both succeed and fill is unchanged.
- Simultaneous write and read, different VCs: fully independent.
- Flush: i_flush[v] zeroes wr_ptr, rd_ptr, o_ovf[v] and o_udf[v] at the next edge. It overrides any same-cycle write or read to v. Other VCs are unaffected.
- Memory contents are not reset.

## Timing
- Reset (async assert, sync-to-clock release handled upstream) sets, for all VCs:
  - pointers = 0
  - o_fill = 0
  - o_empty = all 1
  - o_full = 0
  - o_afull = 0 (AFULL ≥ 1)
  - o_ovf = 0, o_udf = 0
- o_data during reset is undefined; o_valid = 0.
- Write-to-read latency: 1 cycle. Data written at edge N is visible on o_data (with o_valid = 1) after edge N, given i_rd_vc selects that VC.
- o_data/o_valid follow i_rd_vc combinationally. The head advances after each accepted read edge.
- Status outputs (fill/full/empty/afull) are combinational from registered pointers, so they update one edge after the event.
- Wrap-around: pointers roll over 2^(LGFLEN+1) → 0 with fill still correct.

## Structure
- Package fifo_pkg holds:
  - the clog2 function and the VCW derivation
  - the fill-slice width constant (LGFLEN+1)
- Sub-module vc_fifo_ptr is instantiated NVC times via generate. It holds the pointer pair, fill, status flags and sticky errors for one VC. Its inputs are the accepted-write, accepted-read, attempted-write, attempted-read and flush strobes.
- The top level holds the shared memory, VC decode and output muxing.

## Test plan
- Reset mid-stream: write 3 words to VC0, assert i_reset_n=0 asynchronously → o_fill VC0 = 0, o_empty = all 1 immediately, without waiting for a clock edge.
- Fill/drain one VC, LGFLEN=4, NVC=2:
  - write 0x01..0x10 to VC1 → o_full[1]=1, o_afull[1] set at fill 14, VC0 still empty
  - a 17th write (0xAA) → o_ovf[1]=1
  - read 16 → 0x01..0x10 in order, then o_empty[1]=1
- Interleave: alternating writes VC0 = 0xA0+i and VC1 = 0xB0+i, i = 0..7, then read VC1 then VC0 → each VC returns its own sequence in order.
- Same-cycle write and read, same VC:
  - VC0 holds 4 → fill stays 4, order kept
  - VC0 full → read pops, write dropped, o_ovf[0]=1, fill = 15
  - VC0 empty → write stored, o_udf[0]=1, fill = 1
- Flush with collision: VC1 at fill 5 with o_ovf[1] set; i_flush=2'b10 same cycle as a write to VC1 → fill[1]=0, ovf[1]=0, VC0 untouched.
- Wrap: 40 write/read pairs on VC0 at steady fill 3 → data intact, fill constant at 3 across pointer wrap.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// Shared helpers for the multi-VC FIFO: VC index width and per-VC fill-slice width.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // A single VC still needs a one-bit index so the port exists.
  function automatic int unsigned vcw(input int unsigned nvc);
    return (nvc > 1) ? clog2(nvc) : 1;
  endfunction

  function automatic int unsigned fill_w(input int unsigned lgflen);
    return lgflen + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Write/read port bundle of vc_fifo; master is the router side, slave is the FIFO.
interface vc_fifo_if #(
  parameter int unsigned BW  = 8,
  parameter int unsigned VCW = 1
);
  logic           wr;
  logic [VCW-1:0] wr_vc;
  logic [BW-1:0]  wdata;
  logic           rd;
  logic [VCW-1:0] rd_vc;
  logic [BW-1:0]  rdata;
  logic           valid;

  modport master (
    output wr, wr_vc, wdata, rd, rd_vc,
    input  rdata, valid
  );

  modport slave (
    input  wr, wr_vc, wdata, rd, rd_vc,
    output rdata, valid
  );
endinterface

// File: rtl/vc_fifo_ptr.sv
// Pointer pair, fill level, status flags and sticky errors for one virtual channel.
module vc_fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned LGFLEN = 4,
  parameter int unsigned AFULL  = (1 << LGFLEN) - 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_acc,
  input  logic              i_rd_acc,
  input  logic              i_wr_try,
  input  logic              i_rd_try,
  input  logic              i_flush,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic              o_ovf,
  output logic              o_udf,
  output logic [LGFLEN-1:0] o_wr_addr,
  output logic [LGFLEN-1:0] o_rd_addr
);

  localparam int unsigned FW = fill_w(LGFLEN);
  localparam logic [FW-1:0] PtrOne = FW'(1);

  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic          r_ovf;
  logic          r_udf;
  logic [FW-1:0] w_fill;

  assign w_fill = r_wr_ptr - r_rd_ptr;

  // Flush wins over any same-cycle write, read or error on this VC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (i_wr_acc) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (i_rd_acc) r_rd_ptr <= r_rd_ptr + PtrOne;
      if (i_wr_try && o_full) r_ovf <= 1'b1;
      if (i_rd_try && o_empty) r_udf <= 1'b1;
    end
  end

  assign o_fill    = w_fill;
  assign o_full    = (w_fill == FW'(1 << LGFLEN));
  assign o_empty   = (w_fill == '0);
  assign o_afull   = (w_fill >= FW'(AFULL));
  assign o_ovf     = r_ovf;
  assign o_udf     = r_udf;
  assign o_wr_addr = r_wr_ptr[LGFLEN-1:0];
  assign o_rd_addr = r_rd_ptr[LGFLEN-1:0];

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC synchronous FIFO: NVC queues in one shared array with one write and one read port.
module vc_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4,
  parameter int unsigned NVC    = 2,
  parameter int unsigned AFULL  = (1 << LGFLEN) - 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  vc_fifo_if.slave                     bus,
  input  logic [NVC-1:0]               i_flush,
  output logic [NVC-1:0]               o_full,
  output logic [NVC-1:0]               o_afull,
  output logic [NVC-1:0]               o_empty,
  output logic [NVC*(LGFLEN+1)-1:0]    o_fill,
  output logic [NVC-1:0]               o_ovf,
  output logic [NVC-1:0]               o_udf
);

  localparam int unsigned VCW = vcw(NVC);
  localparam int unsigned D   = 1 << LGFLEN;
  localparam int unsigned FW  = fill_w(LGFLEN);

  logic [BW-1:0]     r_mem [NVC*D];
  logic [NVC-1:0]    w_wr_try;
  logic [NVC-1:0]    w_rd_try;
  logic [NVC-1:0]    w_wr_acc;
  logic [NVC-1:0]    w_rd_acc;
  logic [LGFLEN-1:0] w_wr_lo [NVC];
  logic [LGFLEN-1:0] w_rd_lo [NVC];
  logic [BW-1:0]     w_rdata;
  logic              w_valid;

  // An index >= NVC matches no VC, so such requests vanish without flags.
  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign w_wr_try[v] = bus.wr && (bus.wr_vc == VCW'(v)) && !i_flush[v];
    assign w_rd_try[v] = bus.rd && (bus.rd_vc == VCW'(v)) && !i_flush[v];
    assign w_wr_acc[v] = w_wr_try[v] && !o_full[v];
    assign w_rd_acc[v] = w_rd_try[v] && !o_empty[v];

    vc_fifo_ptr #(
      .LGFLEN (LGFLEN),
      .AFULL  (AFULL)
    ) u_ptr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_wr_acc  (w_wr_acc[v]),
      .i_rd_acc  (w_rd_acc[v]),
      .i_wr_try  (w_wr_try[v]),
      .i_rd_try  (w_rd_try[v]),
      .i_flush   (i_flush[v]),
      .o_fill    (o_fill[v*FW +: FW]),
      .o_full    (o_full[v]),
      .o_empty   (o_empty[v]),
      .o_afull   (o_afull[v]),
      .o_ovf     (o_ovf[v]),
      .o_udf     (o_udf[v]),
      .o_wr_addr (w_wr_lo[v]),
      .o_rd_addr (w_rd_lo[v])
    );
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (w_wr_acc[v]) r_mem[{VCW'(v), w_wr_lo[v]}] <= bus.wdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    w_valid = 1'b0;
    for (int v = 0; v < NVC; v++) begin
      if (bus.rd_vc == VCW'(v)) begin
        w_rdata = r_mem[{VCW'(v), w_rd_lo[v]}];
        w_valid = !o_empty[v];
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.valid = w_valid;

endmodule

// File: tb/tb_vc_fifo.sv
// Directed self-checking bench for vc_fifo (BW=8, LGFLEN=4, NVC=2, AFULL=14).
module tb_vc_fifo;

  localparam int BW = 8;
  localparam int LGFLEN = 4;
  localparam int NVC = 2;
  localparam int FW = LGFLEN + 1;

  logic                clk;
  logic                rst_n;
  logic [NVC-1:0]      flush;
  logic [NVC-1:0]      full;
  logic [NVC-1:0]      afull;
  logic [NVC-1:0]      empty;
  logic [NVC*FW-1:0]   fill;
  logic [NVC-1:0]      ovf;
  logic [NVC-1:0]      udf;

  int n_tests;
  int n_fail;

  vc_fifo_if #(.BW(BW), .VCW(1)) bus ();

  vc_fifo #(
    .BW     (BW),
    .LGFLEN (LGFLEN),
    .NVC    (NVC),
    .AFULL  (14)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus),
    .i_flush   (flush),
    .o_full    (full),
    .o_afull   (afull),
    .o_empty   (empty),
    .o_fill    (fill),
    .o_ovf     (ovf),
    .o_udf     (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] fill_of(input int v);
    return fill[v*FW +: FW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic vc, input logic [7:0] d);
    bus.wr = 1'b1;
    bus.wr_vc = vc;
    bus.wdata = d;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic vc, input logic [7:0] exp);
    bus.rd_vc = vc;
    #1;
    check({tag, " data"}, 32'(bus.rdata), 32'(exp));
    check({tag, " valid"}, 32'(bus.valid), 32'd1);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic both(input logic vc, input logic [7:0] d);
    bus.wr = 1'b1;
    bus.wr_vc = vc;
    bus.wdata = d;
    bus.rd = 1'b1;
    bus.rd_vc = vc;
    tick();
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    flush = '0;
    bus.wr = 1'b0;
    bus.wr_vc = 1'b0;
    bus.wdata = '0;
    bus.rd = 1'b0;
    bus.rd_vc = 1'b0;

    #12;
    check("rst fill", 32'(fill), 32'd0);
    check("rst empty", 32'(empty), 32'h3);
    check("rst full", 32'(full), 32'h0);
    check("rst afull", 32'(afull), 32'h0);
    check("rst ovf", 32'(ovf), 32'h0);
    check("rst udf", 32'(udf), 32'h0);
    check("rst valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) push(1'b0, 8'(8'h60 + i));
    check("mid fill0 pre", 32'(fill_of(0)), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid fill0", 32'(fill_of(0)), 32'd0);
    check("mid empty", 32'(empty), 32'h3);
    check("mid valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill and drain VC1.
    for (int i = 0; i < 16; i++) begin
      push(1'b1, 8'(i + 1));
      if (i == 12) check("afull1 at 13", 32'(afull[1]), 32'd0);
      if (i == 13) check("afull1 at 14", 32'(afull[1]), 32'd1);
    end
    check("full1", 32'(full[1]), 32'd1);
    check("fill1 16", 32'(fill_of(1)), 32'd16);
    check("vc0 empty", 32'(empty[0]), 32'd1);
    check("vc0 not full", 32'(full[0]), 32'd0);
    push(1'b1, 8'hAA);
    check("ovf1", 32'(ovf), 32'h2);
    check("fill1 after ovf", 32'(fill_of(1)), 32'd16);
    for (int i = 0; i < 16; i++) pop_check("drain1", 1'b1, 8'(i + 1));
    check("empty1", 32'(empty[1]), 32'd1);
    check("udf none", 32'(udf), 32'h0);

    // Interleaved VCs.
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 8'(8'hA0 + i));
      push(1'b1, 8'(8'hB0 + i));
    end
    check("il fill0", 32'(fill_of(0)), 32'd8);
    check("il fill1", 32'(fill_of(1)), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("il vc1", 1'b1, 8'(8'hB0 + i));
    for (int i = 0; i < 8; i++) pop_check("il vc0", 1'b0, 8'(8'hA0 + i));
    check("il empty", 32'(empty), 32'h3);

    // Same-cycle write and read on a partly filled VC0.
    for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h10 + i));
    bus.rd_vc = 1'b0;
    #1;
    check("rw4 head", 32'(bus.rdata), 32'h10);
    both(1'b0, 8'h20);
    check("rw4 fill", 32'(fill_of(0)), 32'd4);
    pop_check("rw4 order", 1'b0, 8'h11);
    pop_check("rw4 order", 1'b0, 8'h12);
    pop_check("rw4 order", 1'b0, 8'h13);
    pop_check("rw4 order", 1'b0, 8'h20);
    check("rw4 empty", 32'(empty[0]), 32'd1);

    // Same-cycle write and read on a full VC0.
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h40 + i));
    check("rwf full", 32'(full[0]), 32'd1);
    both(1'b0, 8'hEE);
    check("rwf fill", 32'(fill_of(0)), 32'd15);
    check("rwf ovf0", 32'(ovf[0]), 32'd1);
    check("rwf not full", 32'(full[0]), 32'd0);
    for (int i = 0; i < 15; i++) pop_check("rwf drain", 1'b0, 8'(8'h41 + i));
    check("rwf empty", 32'(empty[0]), 32'd1);

    // Same-cycle write and read on an empty VC0.
    check("rwe udf pre", 32'(udf[0]), 32'd0);
    both(1'b0, 8'h77);
    check("rwe fill", 32'(fill_of(0)), 32'd1);
    check("rwe udf0", 32'(udf[0]), 32'd1);
    pop_check("rwe data", 1'b0, 8'h77);

    // Flush VC1 while a write targets it; VC0 must be left alone.
    push(1'b0, 8'h31);
    push(1'b0, 8'h32);
    for (int i = 0; i < 5; i++) push(1'b1, 8'(8'h51 + i));
    check("fl fill1 pre", 32'(fill_of(1)), 32'd5);
    check("fl ovf1 pre", 32'(ovf[1]), 32'd1);
    flush = 2'b10;
    push(1'b1, 8'h99);
    flush = 2'b00;
    check("fl fill1", 32'(fill_of(1)), 32'd0);
    check("fl ovf1", 32'(ovf[1]), 32'd0);
    check("fl empty1", 32'(empty[1]), 32'd1);
    check("fl fill0", 32'(fill_of(0)), 32'd2);
    check("fl ovf0 kept", 32'(ovf[0]), 32'd1);
    check("fl udf0 kept", 32'(udf[0]), 32'd1);
    pop_check("fl vc0", 1'b0, 8'h31);
    pop_check("fl vc0", 1'b0, 8'h32);

    // Steady fill of 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'hC0 + i);
      push(1'b0, d);
      q.push_back(d);
    end
    for (int i = 0; i < 40; i++) begin
      d = 8'(i);
      bus.rd_vc = 1'b0;
      #1;
      check("wrap data", 32'(bus.rdata), 32'(q[0]));
      both(1'b0, d);
      void'(q.pop_front());
      q.push_back(d);
      check("wrap fill", 32'(fill_of(0)), 32'd3);
    end
    for (int i = 0; i < 3; i++) pop_check("wrap tail", 1'b0, q.pop_front());
    check("wrap empty", 32'(empty[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
